// File: rtl/alu_ctrl_pkg.sv
// Shared constants for the ALU control unit: operation codes, ALU_Op classes,
// funct7 patterns, sequencer state encoding and the decode result record.
package alu_ctrl_pkg;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_LUI  = 4'b0001;
  localparam logic [3:0] OP_OR   = 4'b0010;
  localparam logic [3:0] OP_SLL  = 4'b0011;
  localparam logic [3:0] OP_SUB  = 4'b0100;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_XOR  = 4'b0110;
  localparam logic [3:0] OP_BNE  = 4'b0111;
  localparam logic [3:0] OP_BLT  = 4'b1000;
  localparam logic [3:0] OP_AND  = 4'b1001;
  localparam logic [3:0] OP_MUL  = 4'b1010;
  localparam logic [3:0] OP_MULH = 4'b1011;
  localparam logic [3:0] OP_DIV  = 4'b1100;
  localparam logic [3:0] OP_REM  = 4'b1101;
  localparam logic [3:0] OP_SRA  = 4'b1110;
  localparam logic [3:0] OP_JAL  = 4'b1111;

  localparam logic [2:0] ALU_R    = 3'b000;
  localparam logic [2:0] ALU_I    = 3'b001;
  localparam logic [2:0] ALU_LUI  = 3'b010;
  localparam logic [2:0] ALU_BR   = 3'b011;
  localparam logic [2:0] ALU_JAL  = 3'b100;
  localparam logic [2:0] ALU_JALR = 3'b101;
  localparam logic [2:0] ALU_LS   = 3'b110;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_BUSY = 2'b01;
  localparam logic [1:0] ST_DONE = 2'b10;

  typedef struct packed {
    logic [3:0] op;
    logic       illegal;
    logic       is_muldiv;
  } dec_t;

  localparam dec_t DEC_ILLEGAL = '{op: OP_ADD, illegal: 1'b1, is_muldiv: 1'b0};

  function automatic dec_t dec_legal(input logic [3:0] op, input logic is_muldiv);
    dec_t d;
    d.op        = op;
    d.illegal   = 1'b0;
    d.is_muldiv = is_muldiv;
    return d;
  endfunction

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational decode of ALU_Op/funct7/funct3 into an operation code, an
// illegal flag and an M-extension flag. M decode exists only with ALU_CTRL_MULDIV_EN.
module alu_ctrl_decode
  import alu_ctrl_pkg::*;
(
  input  logic [2:0] alu_op,
  input  logic [6:0] funct7,
  input  logic [2:0] funct3,
  output dec_t       dec
);

  always_comb begin
    dec = DEC_ILLEGAL;
    case (alu_op)
      ALU_R: begin
        if (funct7 == F7_BASE) begin
          case (funct3)
            3'b000:  dec = dec_legal(OP_ADD, 1'b0);
            3'b001:  dec = dec_legal(OP_SLL, 1'b0);
            3'b100:  dec = dec_legal(OP_XOR, 1'b0);
            3'b101:  dec = dec_legal(OP_SRL, 1'b0);
            3'b110:  dec = dec_legal(OP_OR,  1'b0);
            3'b111:  dec = dec_legal(OP_AND, 1'b0);
            default: dec = DEC_ILLEGAL;
          endcase
        end else if (funct7 == F7_ALT) begin
          case (funct3)
            3'b000:  dec = dec_legal(OP_SUB, 1'b0);
            3'b101:  dec = dec_legal(OP_SRA, 1'b0);
            default: dec = DEC_ILLEGAL;
          endcase
`ifdef ALU_CTRL_MULDIV_EN
        end else if (funct7 == F7_MULDIV) begin
          // Signed/unsigned variants share a code; the mul-div unit reads funct3 itself.
          case (funct3)
            3'b000:                 dec = dec_legal(OP_MUL,  1'b1);
            3'b001, 3'b010, 3'b011: dec = dec_legal(OP_MULH, 1'b1);
            3'b100, 3'b101:         dec = dec_legal(OP_DIV,  1'b1);
            default:                dec = dec_legal(OP_REM,  1'b1);
          endcase
`endif
        end
      end
      ALU_I: begin
        case (funct3)
          3'b000:  dec = dec_legal(OP_ADD, 1'b0);
          3'b100:  dec = dec_legal(OP_XOR, 1'b0);
          3'b110:  dec = dec_legal(OP_OR,  1'b0);
          3'b111:  dec = dec_legal(OP_AND, 1'b0);
          3'b001:  dec = (funct7 == F7_BASE) ? dec_legal(OP_SLL, 1'b0) : DEC_ILLEGAL;
          3'b101: begin
            if (funct7 == F7_BASE)     dec = dec_legal(OP_SRL, 1'b0);
            else if (funct7 == F7_ALT) dec = dec_legal(OP_SRA, 1'b0);
            else                       dec = DEC_ILLEGAL;
          end
          default: dec = DEC_ILLEGAL;
        endcase
      end
      ALU_LUI: dec = dec_legal(OP_LUI, 1'b0);
      ALU_BR: begin
        case (funct3)
          3'b000:  dec = dec_legal(OP_SUB, 1'b0);
          3'b001:  dec = dec_legal(OP_BNE, 1'b0);
          3'b100:  dec = dec_legal(OP_BLT, 1'b0);
          default: dec = DEC_ILLEGAL;
        endcase
      end
      ALU_JAL:          dec = dec_legal(OP_JAL, 1'b0);
      ALU_JALR, ALU_LS: dec = dec_legal(OP_ADD, 1'b0);
      default:          dec = DEC_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/alu_control_seq.sv
// ALU control with a multi-cycle mul/div sequencer (IDLE -> BUSY -> DONE).
// Sequencer, counter and op latch exist only when ALU_CTRL_MULDIV_EN is defined.
module alu_control_seq
  import alu_ctrl_pkg::*;
#(
  parameter int OP_W    = 4,
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            valid_i,
  input  logic            flush_i,
  input  logic [2:0]      ALU_Op_i,
  input  logic [6:0]      funct7_i,
  input  logic [2:0]      funct3_i,
  output logic [OP_W-1:0] ALU_Operation_o,
  output logic            illegal_o,
  output logic            stall_o,
  output logic            muldiv_start_o,
  output logic            muldiv_done_o,
  output logic [1:0]      state_o
);

  dec_t            dec;
  logic [OP_W-1:0] dec_op;

  alu_ctrl_decode u_decode (
    .alu_op (ALU_Op_i),
    .funct7 (funct7_i),
    .funct3 (funct3_i),
    .dec    (dec)
  );

  assign dec_op    = valid_i ? OP_W'(dec.op) : OP_W'(OP_ADD);
  assign illegal_o = valid_i & dec.illegal;

`ifdef ALU_CTRL_MULDIV_EN
  localparam int CNT_W = (DIV_LAT > 1) ? $clog2(DIV_LAT) : 1;

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       op_lat;
  logic             launch;
  logic             is_mul;

  // Handshake: muldiv_start_o pulses for the one accepted cycle; muldiv_done_o
  // pulses once when the result commits. A flush or reset cancels without done.
  assign launch  = (state == ST_IDLE) & valid_i & dec.is_muldiv & ~flush_i & ~reset;
  assign is_mul  = (dec.op == OP_MUL) | (dec.op == OP_MULH);
  assign state_o = state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      op_lat <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (launch) begin
            state  <= ST_BUSY;
            op_lat <= dec.op;
            cnt    <= is_mul ? CNT_W'(MUL_LAT - 1) : CNT_W'(DIV_LAT - 1);
          end
        end
        ST_BUSY: begin
          if (flush_i)         state <= ST_IDLE;
          else if (cnt == '0)  state <= ST_DONE;
          else                 cnt   <= cnt - 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    stall_o         = 1'b0;
    muldiv_start_o  = 1'b0;
    muldiv_done_o   = 1'b0;
    ALU_Operation_o = dec_op;
    case (state)
      ST_IDLE: begin
        stall_o        = launch;
        muldiv_start_o = launch;
      end
      ST_BUSY: begin
        stall_o         = ~flush_i;
        ALU_Operation_o = OP_W'(op_lat);
      end
      ST_DONE: begin
        muldiv_done_o   = ~flush_i;
        ALU_Operation_o = OP_W'(op_lat);
      end
      default: ;
    endcase
  end
`else
  logic unused_ports;

  assign unused_ports    = &{1'b0, clk, reset, flush_i, dec.is_muldiv};
  assign state_o         = ST_IDLE;
  assign ALU_Operation_o = dec_op;
  assign stall_o         = 1'b0;
  assign muldiv_start_o  = 1'b0;
  assign muldiv_done_o   = 1'b0;
`endif

endmodule

// File: tb/tb_alu_control_seq.sv
// Scoreboard bench for alu_control_seq: drivers push expected outputs per cycle,
// a negedge monitor pops and compares. Covers both ALU_CTRL_MULDIV_EN builds.
module tb_alu_control_seq;

  localparam logic [2:0] R  = 3'b000;
  localparam logic [2:0] I  = 3'b001;
  localparam logic [6:0] F0 = 7'b0000000;
  localparam logic [6:0] FA = 7'b0100000;
  localparam logic [6:0] FM = 7'b0000001;

  logic       clk = 1'b0;
  logic       reset;
  logic       valid_i;
  logic       flush_i;
  logic [2:0] ALU_Op_i;
  logic [6:0] funct7_i;
  logic [2:0] funct3_i;
  logic [3:0] ALU_Operation_o;
  logic       illegal_o;
  logic       stall_o;
  logic       muldiv_start_o;
  logic       muldiv_done_o;
  logic [1:0] state_o;

  logic [7:0] exp_q[$];
  string      name_q[$];
  int         checks   = 0;
  int         failures = 0;

  alu_control_seq #(.OP_W(4), .MUL_LAT(4), .DIV_LAT(32)) dut (
    .clk             (clk),
    .reset           (reset),
    .valid_i         (valid_i),
    .flush_i         (flush_i),
    .ALU_Op_i        (ALU_Op_i),
    .funct7_i        (funct7_i),
    .funct3_i        (funct3_i),
    .ALU_Operation_o (ALU_Operation_o),
    .illegal_o       (illegal_o),
    .stall_o         (stall_o),
    .muldiv_start_o  (muldiv_start_o),
    .muldiv_done_o   (muldiv_done_o),
    .state_o         (state_o)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  // packed view {op, illegal, stall, start, done}
  function automatic logic [7:0] ex(input logic [3:0] op, input logic ill, input logic st,
                                    input logic sa, input logic dn);
    return {op, ill, st, sa, dn};
  endfunction

  function automatic logic [7:0] act();
    return {ALU_Operation_o, illegal_o, stall_o, muldiv_start_o, muldiv_done_o};
  endfunction

  task automatic check(input string name, input logic [7:0] actual, input logic [7:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got op/ill/stall/start/done=%b expected %b", name, actual, expected);
    end
  endtask

  // driver
  task automatic step(input logic v, input logic fl, input logic [2:0] aop,
                      input logic [6:0] f7, input logic [2:0] f3,
                      input logic [7:0] exp, input string name);
    @(posedge clk);
    #1;
    valid_i  = v;
    flush_i  = fl;
    ALU_Op_i = aop;
    funct7_i = f7;
    funct3_i = f3;
    exp_q.push_back(exp);
    name_q.push_back(name);
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [7:0] e;
      string      n;
      e = exp_q.pop_front();
      n = name_q.pop_front();
      check(n, act(), e);
    end
  end

  initial begin
    reset    = 1'b1;
    valid_i  = 1'b0;
    flush_i  = 1'b0;
    ALU_Op_i = 3'b000;
    funct7_i = 7'b0;
    funct3_i = 3'b0;
    #2;
    check("reset_outputs", act(), ex(4'b0000, 0, 0, 0, 0));
    check("reset_state", {6'b0, state_o}, 8'd0);
    @(negedge clk);
    reset = 1'b0;

    step(0, 0, R, F0, 3'b000, ex(4'b0000, 0, 0, 0, 0), "idle");
    // R-type sweep
    step(1, 0, R, F0, 3'b000, ex(4'b0000, 0, 0, 0, 0), "r_add");
    step(1, 0, R, FA, 3'b000, ex(4'b0100, 0, 0, 0, 0), "r_sub");
    step(1, 0, R, F0, 3'b111, ex(4'b1001, 0, 0, 0, 0), "r_and");
    step(1, 0, R, F0, 3'b100, ex(4'b0110, 0, 0, 0, 0), "r_xor");
    step(1, 0, R, F0, 3'b001, ex(4'b0011, 0, 0, 0, 0), "r_sll");
    step(1, 0, R, F0, 3'b101, ex(4'b0101, 0, 0, 0, 0), "r_srl");
    step(1, 0, R, FA, 3'b101, ex(4'b1110, 0, 0, 0, 0), "r_sra");
    step(1, 0, R, F0, 3'b110, ex(4'b0010, 0, 0, 0, 0), "r_or");
    step(1, 0, R, 7'b0000010, 3'b000, ex(4'b0000, 1, 0, 0, 0), "r_bad_f7");
    step(0, 0, R, 7'b0000010, 3'b000, ex(4'b0000, 0, 0, 0, 0), "r_bad_f7_novalid");
    step(1, 0, R, F0, 3'b010, ex(4'b0000, 1, 0, 0, 0), "r_slt_illegal");
    // other classes
    step(1, 0, I, 7'b1111111, 3'b000, ex(4'b0000, 0, 0, 0, 0), "i_addi_any_f7");
    step(1, 0, I, FA, 3'b101, ex(4'b1110, 0, 0, 0, 0), "i_srai");
    step(1, 0, I, FA, 3'b001, ex(4'b0000, 1, 0, 0, 0), "i_slli_bad_f7");
    step(1, 0, 3'b010, F0, 3'b000, ex(4'b0001, 0, 0, 0, 0), "lui");
    step(1, 0, 3'b011, F0, 3'b000, ex(4'b0100, 0, 0, 0, 0), "beq");
    step(1, 0, 3'b011, F0, 3'b001, ex(4'b0111, 0, 0, 0, 0), "bne");
    step(1, 0, 3'b011, F0, 3'b100, ex(4'b1000, 0, 0, 0, 0), "blt");
    step(1, 0, 3'b011, F0, 3'b101, ex(4'b0000, 1, 0, 0, 0), "bge_illegal");
    step(1, 0, 3'b100, F0, 3'b000, ex(4'b1111, 0, 0, 0, 0), "jal");
    step(1, 0, 3'b101, F0, 3'b000, ex(4'b0000, 0, 0, 0, 0), "jalr");
    step(1, 0, 3'b110, F0, 3'b010, ex(4'b0000, 0, 0, 0, 0), "load_store");
    step(1, 0, 3'b111, F0, 3'b000, ex(4'b0000, 1, 0, 0, 0), "class_111_illegal");
    step(0, 0, R, F0, 3'b000, ex(4'b0000, 0, 0, 0, 0), "idle_gap");

`ifdef ALU_CTRL_MULDIV_EN
    // MUL: start at T, stall T..T+4, done T+5, op held while funct3 toggles
    step(1, 0, R, FM, 3'b000, ex(4'b1010, 0, 1, 1, 0), "mul_launch");
    for (int i = 0; i < 4; i++)
      step(1, 0, R, FM, (i % 2 == 0) ? 3'b100 : 3'b110, ex(4'b1010, 0, 1, 0, 0), "mul_busy");
    step(1, 0, R, FM, 3'b000, ex(4'b1010, 0, 0, 0, 1), "mul_done");
    step(0, 0, R, F0, 3'b000, ex(4'b0000, 0, 0, 0, 0), "mul_after");

    // DIVU: 33 stall cycles, one done, held valid in DONE does not relaunch
    step(1, 0, R, FM, 3'b101, ex(4'b1100, 0, 1, 1, 0), "divu_launch");
    for (int i = 0; i < 32; i++)
      step(1, 0, R, FM, 3'b101, ex(4'b1100, 0, 1, 0, 0), "divu_busy");
    step(1, 0, R, FM, 3'b101, ex(4'b1100, 0, 0, 0, 1), "divu_done");
    step(1, 0, R, F0, 3'b000, ex(4'b0000, 0, 0, 0, 0), "divu_next_add");

    // MULHU then REMU decode
    step(1, 0, R, FM, 3'b011, ex(4'b1011, 0, 1, 1, 0), "mulhu_launch");
    for (int i = 0; i < 4; i++)
      step(1, 0, R, FM, 3'b011, ex(4'b1011, 0, 1, 0, 0), "mulhu_busy");
    step(1, 0, R, FM, 3'b011, ex(4'b1011, 0, 0, 0, 1), "mulhu_done");
    step(1, 0, R, FM, 3'b111, ex(4'b1101, 0, 1, 1, 0), "remu_back_to_back");
    step(1, 1, R, FM, 3'b111, ex(4'b1101, 0, 0, 0, 0), "remu_flush_busy1");
    step(0, 0, R, F0, 3'b000, ex(4'b0000, 0, 0, 0, 0), "remu_flushed_idle");

    // flush in the 3rd BUSY cycle of DIV
    step(1, 0, R, FM, 3'b100, ex(4'b1100, 0, 1, 1, 0), "div_launch");
    step(1, 0, R, FM, 3'b100, ex(4'b1100, 0, 1, 0, 0), "div_busy1");
    step(1, 0, R, FM, 3'b100, ex(4'b1100, 0, 1, 0, 0), "div_busy2");
    step(1, 1, R, FM, 3'b100, ex(4'b1100, 0, 0, 0, 0), "div_flush_busy3");
    step(1, 0, R, F0, 3'b000, ex(4'b0000, 0, 0, 0, 0), "post_flush_add");
    step(0, 0, R, F0, 3'b000, ex(4'b0000, 0, 0, 0, 0), "post_flush_idle");

    // flush in IDLE suppresses launch
    step(1, 1, R, FM, 3'b000, ex(4'b1010, 0, 0, 0, 0), "mul_flush_idle");
    step(0, 0, R, F0, 3'b000, ex(4'b0000, 0, 0, 0, 0), "mul_flush_no_launch");

    // asynchronous reset mid-MUL
    step(1, 0, R, FM, 3'b000, ex(4'b1010, 0, 1, 1, 0), "rst_mul_launch");
    step(1, 0, R, FM, 3'b000, ex(4'b1010, 0, 1, 0, 0), "rst_mul_busy");
    @(posedge clk);
    #2;
    reset   = 1'b1;
    valid_i = 1'b0;
    #1;
    check("reset_abort_outputs", act(), ex(4'b0000, 0, 0, 0, 0));
    check("reset_abort_state", {6'b0, state_o}, 8'd0);
    #3;
    reset = 1'b0;
    step(0, 0, R, F0, 3'b000, ex(4'b0000, 0, 0, 0, 0), "after_reset_idle");
    step(0, 0, R, F0, 3'b000, ex(4'b0000, 0, 0, 0, 0), "after_reset_no_done");
`else
    // M-extension compiled out: decodes as illegal, never stalls
    step(1, 0, R, FM, 3'b000, ex(4'b0000, 1, 0, 0, 0), "mul_illegal");
    step(1, 0, R, FM, 3'b000, ex(4'b0000, 1, 0, 0, 0), "mul_held_no_stall");
    step(1, 0, R, FM, 3'b101, ex(4'b0000, 1, 0, 0, 0), "divu_illegal");
    step(1, 1, R, FM, 3'b111, ex(4'b0000, 1, 0, 0, 0), "remu_flush_illegal");
    step(0, 0, R, FM, 3'b000, ex(4'b0000, 0, 0, 0, 0), "mul_novalid");
    @(negedge clk);
    #1;
    check("disabled_state", {6'b0, state_o}, 8'd0);
`endif

    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL queue_drained: got %0d pending expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_control_seq.md
# alu_control_seq

Parametrised next-generation ALU control unit for the RV32 datapath's execute stage. It decodes ALU_Op_i, the full funct7_i and funct3_i into an ALU operation code, flags undecodable encodings, and adds a multi-cycle sequencer for RV32M multiply/divide. The sequencer stalls the pipeline for a programmable latency and holds the operation code stable until the result commits. It replaces the single-cycle combinational ALU control.

## Interface
Parameters:
- OP_W, 4: ALU operation code width; must be >= 4; codes are zero-extended.
- MUL_LAT, 4: BUSY cycles for MUL/MULH/MULHSU/MULHU; >= 1.
- DIV_LAT, 32: BUSY cycles for DIV/DIVU/REM/REMU; >= 1 and >= MUL_LAT.

Ports (clock and reset first):
- clk  in  1  single clock for the block
- reset  in  1  asynchronous, active-high; forces the sequencer to IDLE
- valid_i  in  1  a valid instruction is in execute
- flush_i  in  1  kill the execute-stage instruction
- ALU_Op_i  in  3  main-control class: 000 R, 001 I-arith, 010 LUI, 011 branch, 100 JAL, 101 JALR, 110 load/store
- funct7_i  in  7  instruction[31:25]
- funct3_i  in  3  instruction[14:12]
- ALU_Operation_o  out  OP_W  operation code to the ALU / mul-div unit
- illegal_o  out  1  valid_i is high and the encoding is undecodable
- stall_o  out  1  hold IF/ID/EX this cycle
- muldiv_start_o  out  1  one-cycle pulse that launches the mul-div unit
- muldiv_done_o  out  1  one-cycle pulse; mul-div result valid, instruction commits

## Operation
- Operation codes: ADD 0000, LUI 0001, OR 0010, SLL 0011, SUB 0100, SRL 0101, XOR 0110, BNE 0111, BLT 1000, AND 1001, MUL 1010, MULH 1011, DIV 1100, REM 1101, SRA 1110, JAL 1111.
- MULHSU and MULHU map to MULH. DIVU maps to DIV. REMU maps to REM. Signedness comes from funct3, which the mul-div unit reads directly.
- Decode rules:
  - R-type requires funct7 of 0000000, or 0100000 for SUB/SRA.
  - I-shifts check funct7. Other I-arith ignore funct7.
  - Branch funct3: 000 maps to SUB (beq), 001 to BNE, 100 to BLT.
  - Load/store and JALR map to ADD.
  - Any other combination gives code ADD with illegal_o=1.
- M-extension condition: ALU_Op_i=000 and funct7_i=0000001.
- State machine (IDLE, BUSY, DONE):
  - IDLE:
    - ALU_Operation_o is the combinational decode; ADD when valid_i=0.
    - On valid_i & M-op & ~flush_i: stall_o=1, muldiv_start_o=1, latch the op code, load cnt with LAT-1, go to BUSY.
  - BUSY:
    - stall_o=1 and ALU_Operation_o is the latched code.
    - When cnt==0, go to DONE; otherwise decrement cnt.
  - DONE:
    - stall_o=0, muldiv_done_o=1, latched code on ALU_Operation_o, go to IDLE unconditionally.
    - The same instruction leaves EX at the end of this cycle and is never relaunched.
- flush_i in BUSY or DONE: go to IDLE next cycle. stall_o and muldiv_done_o are forced to 0 in that same cycle.
- flush_i in IDLE suppresses the launch.
- Counter width is $clog2(DIV_LAT). It never underflows or wraps.

## Timing
- Single-cycle ops: zero latency, purely combinational, stall_o=0.
- M-op accepted at cycle T:
  - stall_o is high for cycles T through T+LAT.
  - muldiv_done_o is high at T+LAT+1.
  - Total stall is LAT+1 cycles.
- Back-to-back M-ops: the second is seen in IDLE at T+LAT+2. Zero-bubble issue is not supported.
- Reset values: state IDLE, cnt 0, latched code 0. stall_o, muldiv_start_o, muldiv_done_o and illegal_o read 0 while valid_i=0.
- reset asserted mid-operation aborts immediately (asynchronously) with no done pulse.

## Configuration
- ALU_CTRL_MULDIV_EN defined: M-extension decode and the sequencer are compiled in as above.
- ALU_CTRL_MULDIV_EN undefined:
  - funct7=0000001 R-types decode as illegal (ADD, illegal_o=1).
  - State stays in IDLE; stall_o, muldiv_start_o and muldiv_done_o are tied to 0.
  - No counter or latch registers are synthesised.

## Structure
- Shared package alu_ctrl_pkg holds:
  - the operation-code localparams;
  - the ALU_Op class codes;
  - funct7 constants F7_BASE, F7_ALT, F7_MULDIV;
  - the state encoding.
- Sub-module alu_ctrl_decode: purely combinational decode to op code, illegal flag and is_muldiv flag.
- The top level owns the FSM, counter and op latch.

## Test plan
- R ADD/SUB/AND/XOR/SLL/SRL/SRA sweep with valid_i=1: op codes 0000/0100/1001/0110/0011/0101/1110, stall_o=0, illegal_o=0.
- ALU_Op=000, funct7=0000010, funct3=000: op 0000, illegal_o=1. With valid_i=0, illegal_o=0.
- MUL with MUL_LAT=4 at cycle 10:
  - muldiv_start_o at cycle 10 only;
  - stall_o high for cycles 10–14;
  - muldiv_done_o at cycle 15;
  - op stays 1010 throughout, even when funct3_i is toggled during BUSY.
- DIVU with DIV_LAT=32: stall_o high for 33 cycles, op 1100, exactly one done pulse. A held valid_i in DONE does not relaunch.
- flush_i at the 3rd BUSY cycle of DIV: stall_o drops that cycle, IDLE next cycle, no muldiv_done_o. A following ADD decodes with zero stall.
- reset pulse mid-MUL: stall_o and muldiv_done_o drop asynchronously. Build without ALU_CTRL_MULDIV_EN: MUL gives illegal_o=1 and stall_o stays 0.
